// File: rtl/lem_hwi_ctrl_if.sv
// Bus bundle for the LEM1802 HWI sequencer: the CPU-facing HWI command
// handshake plus the DCPU RAM write port. The "slave" modport is the
// controller's view. It answers HWI commands and masters the RAM writes.
// The "master" modport is the CPU/RAM side that drives commands and acks.
interface lem_hwi_ctrl_if;
  logic        hwi_req;
  logic [15:0] hwi_a;
  logic [15:0] hwi_b;
  logic        hwi_busy;
  logic        hwi_done;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;

  modport slave (
    input  hwi_req, hwi_a, hwi_b, mem_ack,
    output hwi_busy, hwi_done, mem_req, mem_addr, mem_wdata
  );

  modport master (
    output hwi_req, hwi_a, hwi_b, mem_ack,
    input  hwi_busy, hwi_done, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lem_hwi_ctrl.sv
// LEM1802 hardware-interrupt command sequencer.
// Decodes HWI commands into the screen/font/palette map registers and the
// border colour. It also copies the default font or palette ROM into DCPU RAM,
// one word per RD/WR pair, over a req/ack write port.
module lem_hwi_ctrl #(
  parameter int FONT_WORDS = 256,
  parameter int PAL_WORDS  = 16
) (
  input  logic          CLOCK_25M,
  input  logic          RST,
  lem_hwi_ctrl_if.slave bus,
  output logic [15:0]   screen_base,
  output logic          screen_en,
  output logic [15:0]   font_base,
  output logic          font_custom,
  output logic [15:0]   pal_base,
  output logic          pal_custom,
  output logic [3:0]    borderColour,
  output logic [7:0]    dflt_font_addr,
  input  logic [15:0]   dflt_font_data,
  output logic [3:0]    dflt_pal_addr,
  input  logic [15:0]   dflt_pal_data
);

  localparam logic [15:0] FONT_LEN = 16'(FONT_WORDS);
  localparam logic [15:0] PAL_LEN  = 16'(PAL_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] idx;
  logic [15:0] idx_nxt;
  logic [15:0] len;
  logic [15:0] b_lat;
  logic [15:0] wbuf;
  logic        dump_font;
  logic        accept;

  // State register and word counter; reset abandons any dump in flight
  always_ff @(posedge CLOCK_25M) begin
    if (RST) begin
      state <= IDLE;
      idx   <= 16'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state and counter logic: one RD (ROM read) and one WR (RAM write) per word
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.hwi_req) begin
          accept = 1'b1;
          if (bus.hwi_a == 16'd4 || bus.hwi_a == 16'd5) begin
            state_nxt = RD;
            idx_nxt   = 16'd0;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RD: state_nxt = WR;
      WR: begin
        if (bus.mem_ack) begin
          if (idx == len - 16'd1) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 16'd1;
            state_nxt = RD;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command decode into the config registers, dump setup, and ROM word capture
  always_ff @(posedge CLOCK_25M) begin
    if (RST) begin
      screen_base  <= 16'd0;
      screen_en    <= 1'b0;
      font_base    <= 16'd0;
      font_custom  <= 1'b0;
      pal_base     <= 16'd0;
      pal_custom   <= 1'b0;
      borderColour <= 4'd0;
      b_lat        <= 16'd0;
      len          <= 16'd0;
      dump_font    <= 1'b0;
      wbuf         <= 16'd0;
    end else begin
      if (accept) begin
        b_lat <= bus.hwi_b;
        case (bus.hwi_a)
          16'd0: begin
            screen_base <= bus.hwi_b;
            screen_en   <= (bus.hwi_b != 16'd0);
          end
          16'd1: begin
            font_base   <= bus.hwi_b;
            font_custom <= (bus.hwi_b != 16'd0);
          end
          16'd2: begin
            pal_base   <= bus.hwi_b;
            pal_custom <= (bus.hwi_b != 16'd0);
          end
          16'd3: borderColour <= bus.hwi_b[3:0];
          16'd4: begin
            dump_font <= 1'b1;
            len       <= FONT_LEN;
          end
          16'd5: begin
            dump_font <= 1'b0;
            len       <= PAL_LEN;
          end
          default: ;
        endcase
      end
      if (state == RD) begin
        wbuf <= dump_font ? dflt_font_data : dflt_pal_data;
      end
    end
  end

  // The ROMs register their address, so they are fed the counter's next value.
  // Their data for the current idx is then ready during RD. Address and data
  // come from registers, so they hold steady across ack stalls.
  assign dflt_font_addr = idx_nxt[7:0];
  assign dflt_pal_addr  = idx_nxt[3:0];
  assign bus.hwi_busy   = (state != IDLE);
  assign bus.hwi_done   = (state == DONE);
  assign bus.mem_req    = (state == WR);
  assign bus.mem_addr   = b_lat + idx;
  assign bus.mem_wdata  = wbuf;

endmodule

// File: tb/tb_lem_hwi_ctrl.sv
// Testbench for lem_hwi_ctrl: directed HWI commands. Expected RAM writes and
// expected config snapshots at each hwi_done are queued by the stimulus and
// popped by an independent monitor.
module tb_lem_hwi_ctrl;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  typedef struct {
    logic [15:0] screen_base;
    logic        screen_en;
    logic [15:0] font_base;
    logic        font_custom;
    logic [15:0] pal_base;
    logic        pal_custom;
    logic [3:0]  border;
    int          accept_cyc;
    int          delay;
  } done_exp_t;

  logic        CLOCK_25M;
  logic        RST;
  logic [15:0] screen_base;
  logic        screen_en;
  logic [15:0] font_base;
  logic        font_custom;
  logic [15:0] pal_base;
  logic        pal_custom;
  logic [3:0]  borderColour;
  logic [7:0]  dflt_font_addr;
  logic [15:0] dflt_font_data;
  logic [3:0]  dflt_pal_addr;
  logic [15:0] dflt_pal_data;

  lem_hwi_ctrl_if bus ();

  lem_hwi_ctrl dut (
    .CLOCK_25M     (CLOCK_25M),
    .RST           (RST),
    .bus           (bus),
    .screen_base   (screen_base),
    .screen_en     (screen_en),
    .font_base     (font_base),
    .font_custom   (font_custom),
    .pal_base      (pal_base),
    .pal_custom    (pal_custom),
    .borderColour  (borderColour),
    .dflt_font_addr(dflt_font_addr),
    .dflt_font_data(dflt_font_data),
    .dflt_pal_addr (dflt_pal_addr),
    .dflt_pal_data (dflt_pal_data)
  );

  wr_exp_t     wr_q[$];
  done_exp_t   done_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acks_seen = 0;
  bit          ack_random = 0;
  logic        prev_req = 0;
  logic        prev_ack = 0;
  logic [15:0] prev_addr = 0;
  logic [15:0] prev_data = 0;

  // Reference model of the config registers
  logic [15:0] m_screen_base, m_font_base, m_pal_base;
  logic        m_screen_en, m_font_custom, m_pal_custom;
  logic [3:0]  m_border;

  // Default ROM contents
  function automatic logic [15:0] font_word(input logic [7:0] i);
    return {~i, i};
  endfunction

  function automatic logic [15:0] pal_word(input logic [3:0] i);
    return {4'h0, i, ~i, i};
  endfunction

  initial CLOCK_25M = 1'b0;
  always #20 CLOCK_25M = ~CLOCK_25M;

  // Edge counter used for latency checks
  always @(posedge CLOCK_25M) cyc <= cyc + 1;

  // One-cycle synchronous-read ROM models
  always @(posedge CLOCK_25M) begin
    dflt_font_data <= font_word(dflt_font_addr);
    dflt_pal_data  <= pal_word(dflt_pal_addr);
  end

  // RAM acknowledge: either always ready or randomly stalling
  initial begin
    bus.mem_ack = 1'b1;
    forever begin
      @(posedge CLOCK_25M);
      #5;
      bus.mem_ack = ack_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #(40 * 30000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks RAM writes, stall stability and hwi_done snapshots
  always @(negedge CLOCK_25M) begin
    if (!RST) begin
      if (bus.mem_req && prev_req && !prev_ack) begin
        checkOutput("stall_addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
        checkOutput("stall_data_stable", 32'(bus.mem_wdata), 32'(prev_data));
      end
      if (bus.mem_req && bus.mem_ack) begin
        acks_seen++;
        if (wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          checkOutput("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
          checkOutput("wr_data", 32'(bus.mem_wdata), 32'(w.data));
        end
      end
      if (bus.hwi_done) begin
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_done: hwi_done=1 at cycle %0d, none expected", cyc);
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          checkOutput("done_screen_base", 32'(screen_base), 32'(e.screen_base));
          checkOutput("done_screen_en", 32'(screen_en), 32'(e.screen_en));
          checkOutput("done_font_base", 32'(font_base), 32'(e.font_base));
          checkOutput("done_font_custom", 32'(font_custom), 32'(e.font_custom));
          checkOutput("done_pal_base", 32'(pal_base), 32'(e.pal_base));
          checkOutput("done_pal_custom", 32'(pal_custom), 32'(e.pal_custom));
          checkOutput("done_border", 32'(borderColour), 32'(e.border));
          if (e.delay >= 0) begin
            checkOutput("done_latency", 32'(cyc - e.accept_cyc), 32'(e.delay));
          end
        end
      end
    end
    prev_req  = bus.mem_req;
    prev_ack  = bus.mem_ack;
    prev_addr = bus.mem_addr;
    prev_data = bus.mem_wdata;
  end

  task automatic modelReset();
    m_screen_base = 16'd0;
    m_screen_en = 1'b0;
    m_font_base = 16'd0;
    m_font_custom = 1'b0;
    m_pal_base = 16'd0;
    m_pal_custom = 1'b0;
    m_border = 4'd0;
  endtask

  // Issue one command; delay is the edge count from accept to the DONE cycle (-1 = unchecked)
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input int delay);
    done_exp_t e;
    @(posedge CLOCK_25M);
    #5;
    bus.hwi_req = 1'b1;
    bus.hwi_a = a;
    bus.hwi_b = b;
    @(posedge CLOCK_25M);
    #5;
    bus.hwi_req = 1'b0;
    case (a)
      16'd0: begin m_screen_base = b; m_screen_en = (b != 0); end
      16'd1: begin m_font_base = b; m_font_custom = (b != 0); end
      16'd2: begin m_pal_base = b; m_pal_custom = (b != 0); end
      16'd3: m_border = b[3:0];
      16'd4: for (int i = 0; i < 256; i++) wr_q.push_back('{16'(b + 16'(i)), font_word(8'(i))});
      16'd5: for (int i = 0; i < 16; i++) wr_q.push_back('{16'(b + 16'(i)), pal_word(4'(i))});
      default: ;
    endcase
    e.screen_base = m_screen_base;
    e.screen_en = m_screen_en;
    e.font_base = m_font_base;
    e.font_custom = m_font_custom;
    e.pal_base = m_pal_base;
    e.pal_custom = m_pal_custom;
    e.border = m_border;
    e.accept_cyc = cyc;
    e.delay = delay;
    done_q.push_back(e);
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (bus.hwi_busy && n < limit) begin
      @(posedge CLOCK_25M);
      #5;
      n++;
    end
    checkOutput("idle_timeout", 32'(bus.hwi_busy), 32'd0);
  endtask

  task automatic checkConfigZero(input string tag);
    checkOutput({tag, "_screen_base"}, 32'(screen_base), 32'd0);
    checkOutput({tag, "_screen_en"}, 32'(screen_en), 32'd0);
    checkOutput({tag, "_font_base"}, 32'(font_base), 32'd0);
    checkOutput({tag, "_font_custom"}, 32'(font_custom), 32'd0);
    checkOutput({tag, "_pal_base"}, 32'(pal_base), 32'd0);
    checkOutput({tag, "_pal_custom"}, 32'(pal_custom), 32'd0);
    checkOutput({tag, "_border"}, 32'(borderColour), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.hwi_busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.hwi_done), 32'd0);
    checkOutput({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
  endtask

  // Directed command sequence
  initial begin
    int ack_base;
    RST = 1'b1;
    bus.hwi_req = 1'b0;
    bus.hwi_a = 16'd0;
    bus.hwi_b = 16'd0;
    modelReset();
    repeat (3) @(posedge CLOCK_25M);
    #5;
    checkConfigZero("reset");
    RST = 1'b0;

    // Border colour: done in the cycle after accept, then back to idle
    applyStimulus(16'd3, 16'h00A7, 0);
    checkOutput("border_value", 32'(borderColour), 32'h7);
    checkOutput("border_busy_done_cycle", 32'(bus.hwi_busy), 32'd1);
    @(posedge CLOCK_25M);
    #5;
    checkOutput("border_busy_after", 32'(bus.hwi_busy), 32'd0);
    checkOutput("border_done_after", 32'(bus.hwi_done), 32'd0);

    // Map commands and an unknown command
    applyStimulus(16'd0, 16'h8000, 0);
    waitIdle(10);
    applyStimulus(16'd0, 16'h0000, 0);
    waitIdle(10);
    applyStimulus(16'd1, 16'h2000, 0);
    waitIdle(10);
    applyStimulus(16'd2, 16'h3000, 0);
    waitIdle(10);
    applyStimulus(16'd7, 16'hFFFF, 0);
    waitIdle(10);
    applyStimulus(16'd0, 16'h8000, 0);
    waitIdle(10);

    // Palette dump, ack always ready: 2*16 edges from accept to DONE
    ack_random = 1'b0;
    applyStimulus(16'd5, 16'h1000, 32);
    waitIdle(100);
    checkOutput("pal_dump_drained", 32'(wr_q.size()), 32'd0);

    // Font dump with random stalls and address wrap; a request mid-dump is ignored
    ack_random = 1'b1;
    ack_base = acks_seen;
    applyStimulus(16'd4, 16'hFF80, -1);
    repeat (20) @(posedge CLOCK_25M);
    #5;
    bus.hwi_req = 1'b1;
    bus.hwi_a = 16'd3;
    bus.hwi_b = 16'h000F;
    @(posedge CLOCK_25M);
    #5;
    bus.hwi_req = 1'b0;
    waitIdle(5000);
    ack_random = 1'b0;
    checkOutput("font_dump_acks", 32'(acks_seen - ack_base), 32'd256);
    checkOutput("font_dump_drained", 32'(wr_q.size()), 32'd0);
    checkOutput("border_after_ignored_req", 32'(borderColour), 32'h7);

    // Reset while word 5 of a font dump is waiting to be written
    ack_base = acks_seen;
    applyStimulus(16'd4, 16'h0040, -1);
    for (int i = 0; i < 200 && acks_seen < ack_base + 5; i++) begin
      @(posedge CLOCK_25M);
      #5;
    end
    @(posedge CLOCK_25M);
    #5;
    checkOutput("abort_mem_req_before", 32'(bus.mem_req), 32'd1);
    checkOutput("abort_addr_word5", 32'(bus.mem_addr), 32'h0045);
    RST = 1'b1;
    @(posedge CLOCK_25M);
    #5;
    checkConfigZero("abort");
    wr_q.delete();
    done_q.delete();
    modelReset();
    RST = 1'b0;
    repeat (10) @(posedge CLOCK_25M);
    #5;
    checkOutput("abort_stays_idle", 32'(bus.hwi_busy), 32'd0);

    // Controller accepts commands again after the abort
    applyStimulus(16'd3, 16'h0005, 0);
    waitIdle(10);
    checkOutput("recover_border", 32'(borderColour), 32'h5);
    checkOutput("final_done_q_empty", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
